phase_align_scan_ctrl: RTL and testbench

Multi-channel successor to the single-channel DCO/DCH alignment FSM. For each of NCH deserializer channels, it sweeps a dynamic phase shifter across its full tap range and checks the channel's training-pattern comparator at every tap. It records the widest contiguous good window, then parks the channel at the window centre. The block sits between the ADC-unit pattern checkers and the per-channel phase shifters, and runs on request after power-up or re-sync.

---
 rtl/phase_align_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_phase_align_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_align_scan_ctrl.sv
// Sequential multi-channel phase-alignment scanner: sweeps each channel's phase shifter
// over every tap, keeps the widest stable training-pattern window and parks at its centre.
module phase_align_scan_ctrl #(
    parameter  int NCH        = 8,
    parameter  int TAPS       = 64,
    parameter  int STABLE_CYC = 4095,
    parameter  int SETTLE_CYC = 4,
    parameter  int MIN_EYE    = 4,
    parameter  int PS_TMO     = 255,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TAP_W      = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NCH-1:0]     pattern_ok,
    input  logic               ps_done,
    output logic [CH_W-1:0]    ch_sel,
    output logic               ps_en,
    output logic               ps_incdec,
    output logic               busy,
    output logic               done,
    output logic [NCH-1:0]     ch_locked,
    output logic [NCH-1:0]     ch_fail,
    output logic               res_valid,
    output logic [TAP_W-1:0]   res_left,
    output logic [TAP_W:0]     res_width
);
    localparam int CNT_MAX0 = (STABLE_CYC > PS_TMO) ? STABLE_CYC : PS_TMO;
    localparam int CNT_MAX  = (CNT_MAX0 > SETTLE_CYC) ? CNT_MAX0 : SETTLE_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_END    = CNT_W'(PS_TMO - 1);
    localparam logic [TAP_W-1:0] TAP_ONE    = TAP_W'(1);
    localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_MID    = TAP_W'(TAPS / 2);
    localparam logic [TAP_W:0]   LEN_ONE    = (TAP_W + 1)'(1);
    localparam logic [TAP_W:0]   MIN_EYE_W  = (TAP_W + 1)'(MIN_EYE);
    localparam logic [CH_W-1:0]  CH_ONE     = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NCH - 1);

    typedef enum logic [3:0] {
        IDLE, HOME, HWAIT, SETTLE, CHECK, SCORE, NWAIT,
        EVAL, CENTER, CWAIT, RESULT, DONE
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [TAP_W-1:0]   tap_q [NCH];
    logic [CNT_W-1:0]   cnt_q;
    logic               good_q;
    logic               fail_q;
    logic               tmo_q;
    logic [TAP_W-1:0]   cur_start_q;
    logic [TAP_W:0]     cur_len_q;
    logic [TAP_W-1:0]   best_start_q;
    logic [TAP_W:0]     best_len_q;
    logic [TAP_W-1:0]   target_q;
    logic               ps_en_q;
    logic               ps_incdec_q;
    logic               busy_q;
    logic               done_q;
    logic [NCH-1:0]     locked_q;
    logic [NCH-1:0]     fail_vec_q;
    logic               res_valid_q;
    logic [TAP_W-1:0]   res_left_q;
    logic [TAP_W:0]     res_width_q;

    logic [TAP_W-1:0]   tap_cur;
    logic [TAP_W:0]     cur_len_inc;
    logic [TAP_W-1:0]   cur_start_nxt;
    logic [TAP_W-1:0]   centre;

    assign tap_cur       = tap_q[ch_q];
    assign cur_len_inc   = cur_len_q + LEN_ONE;
    assign cur_start_nxt = (cur_len_q == '0) ? tap_cur : cur_start_q;
    assign centre        = best_start_q + TAP_W'(best_len_q >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            // NOTE: the tap array mirrors the shifters' own positions, and the shifters
            // reset to tap 0 on the same rst, so this small array must be reset as well.
            tap_q        <= '{default: '0};
            cnt_q        <= '0;
            good_q       <= 1'b0;
            fail_q       <= 1'b0;
            tmo_q        <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            target_q     <= '0;
            ps_en_q      <= 1'b0;
            ps_incdec_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= '0;
            fail_vec_q   <= '0;
            res_valid_q  <= 1'b0;
            res_left_q   <= '0;
            res_width_q  <= '0;
        end else begin
            // NOTE: strobes default low here so each one lasts exactly one cycle.
            ps_en_q     <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q       <= 1'b1;
                        locked_q     <= '0;
                        fail_vec_q   <= '0;
                        ch_q         <= '0;
                        cur_len_q    <= '0;
                        cur_start_q  <= '0;
                        best_len_q   <= '0;
                        best_start_q <= '0;
                        fail_q       <= 1'b0;
                        tmo_q        <= 1'b0;
                        state_q      <= HOME;
                    end
                end
                HOME: begin
                    cnt_q <= '0;
                    if (tap_cur == '0) begin
                        state_q <= SETTLE;
                    end else begin
                        ps_en_q     <= 1'b1;
                        ps_incdec_q <= 1'b0;
                        state_q     <= HWAIT;
                    end
                end
                HWAIT, CWAIT: begin
                    if (ps_done) begin
                        tap_q[ch_q] <= tap_cur - TAP_ONE;
                        state_q     <= (state_q == HWAIT) ? HOME : CENTER;
                    end else if (cnt_q == TMO_END) begin
                        fail_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        state_q <= RESULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_END) begin
                        cnt_q   <= '0;
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                CHECK: begin
                    // A single low sample condemns the tap; no need to finish the window.
                    if (!pattern_ok[ch_q]) begin
                        good_q  <= 1'b0;
                        state_q <= SCORE;
                    end else if (cnt_q == STABLE_END) begin
                        good_q  <= 1'b1;
                        state_q <= SCORE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SCORE: begin
                    if (good_q) begin
                        cur_len_q   <= cur_len_inc;
                        cur_start_q <= cur_start_nxt;
                        if (cur_len_inc > best_len_q) begin
                            best_start_q <= cur_start_nxt;
                            best_len_q   <= cur_len_inc;
                        end
                    end else begin
                        cur_len_q <= '0;
                    end
                    cnt_q <= '0;
                    if (tap_cur == TAP_LAST) begin
                        state_q <= EVAL;
                    end else begin
                        ps_en_q     <= 1'b1;
                        ps_incdec_q <= 1'b1;
                        state_q     <= NWAIT;
                    end
                end
                NWAIT: begin
                    if (ps_done) begin
                        tap_q[ch_q] <= tap_cur + TAP_ONE;
                        cnt_q       <= '0;
                        state_q     <= SETTLE;
                    end else if (cnt_q == TMO_END) begin
                        fail_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        state_q <= RESULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                EVAL: begin
                    if (best_len_q >= MIN_EYE_W) begin
                        target_q <= centre;
                    end else begin
                        target_q <= TAP_MID;
                        fail_q   <= 1'b1;
                    end
                    state_q <= CENTER;
                end
                CENTER: begin
                    cnt_q <= '0;
                    if (tap_cur == target_q) begin
                        state_q <= RESULT;
                    end else begin
                        ps_en_q     <= 1'b1;
                        ps_incdec_q <= 1'b0;
                        state_q     <= CWAIT;
                    end
                end
                RESULT: begin
                    res_valid_q <= 1'b1;
                    res_left_q  <= best_start_q;
                    res_width_q <= tmo_q ? '0 : best_len_q;
                    if (fail_q) fail_vec_q[ch_q] <= 1'b1;
                    else        locked_q[ch_q]   <= 1'b1;
                    cur_len_q    <= '0;
                    cur_start_q  <= '0;
                    best_len_q   <= '0;
                    best_start_q <= '0;
                    fail_q       <= 1'b0;
                    tmo_q        <= 1'b0;
                    if (ch_q == CH_LAST) begin
                        state_q <= DONE;
                    end else begin
                        ch_q    <= ch_q + CH_ONE;
                        state_q <= HOME;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ch_q    <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_sel    = ch_q;
    assign ps_en     = ps_en_q;
    assign ps_incdec = ps_incdec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ch_locked = locked_q;
    assign ch_fail   = fail_vec_q;
    assign res_valid = res_valid_q;
    assign res_left  = res_left_q;
    assign res_width = res_width_q;

endmodule

// File: tb/tb_phase_align_scan_ctrl.sv
// Directed bench for phase_align_scan_ctrl: a two-channel shifter model with per-tap
// pattern masks, completing each step 3 cycles after ps_en.
module tb_phase_align_scan_ctrl;
    localparam int NCH        = 2;
    localparam int TAPS       = 16;
    localparam int STABLE_CYC = 8;
    localparam int SETTLE_CYC = 2;
    localparam int MIN_EYE    = 4;
    localparam int PS_TMO     = 20;
    localparam int TAP_W      = 4;
    localparam int BUDGET     = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NCH-1:0]   pattern_ok;
    logic             ps_done = 1'b0;
    logic [0:0]       ch_sel;
    logic             ps_en;
    logic             ps_incdec;
    logic             busy;
    logic             done;
    logic [NCH-1:0]   ch_locked;
    logic [NCH-1:0]   ch_fail;
    logic             res_valid;
    logic [TAP_W-1:0] res_left;
    logic [TAP_W:0]   res_width;

    phase_align_scan_ctrl #(
        .NCH(NCH), .TAPS(TAPS), .STABLE_CYC(STABLE_CYC),
        .SETTLE_CYC(SETTLE_CYC), .MIN_EYE(MIN_EYE), .PS_TMO(PS_TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pattern_ok(pattern_ok),
        .ps_done(ps_done), .ch_sel(ch_sel), .ps_en(ps_en), .ps_incdec(ps_incdec),
        .busy(busy), .done(done), .ch_locked(ch_locked), .ch_fail(ch_fail),
        .res_valid(res_valid), .res_left(res_left), .res_width(res_width)
    );

    always #5 clk = ~clk;

    // Shifter/channel model state
    logic [TAPS-1:0] mask [NCH];
    int   mtap [NCH];
    int   dly = 0;
    int   pend_ch = 0;
    logic pend_dir = 1'b0;
    int   step_no = 0;
    int   withhold_step = 0;
    logic glitch_arm = 1'b0;
    logic glitch_fired = 1'b0;
    logic glitch_on = 1'b0;
    int   glitch_cnt = 0;

    // Observation state
    int   cyc = 0;
    int   en_cnt = 0;
    int   done_cnt = 0;
    int   hdec0 = 0;
    logic seen_inc0 = 1'b0;
    logic ch1_inc_seen = 1'b0;
    logic busy_prev = 1'b0;
    int   res_n = 0;
    int   res_l [4];
    int   res_w [4];
    int   tmo_en_cyc = 0;
    int   res_cyc0 = 0;

    int vectors = 0;
    int miscompares = 0;

    always_comb begin
        for (int c = 0; c < NCH; c++)
            pattern_ok[c] = mask[c][mtap[c]] && !(glitch_on && (c == 0));
    end

    always @(negedge clk) begin
        cyc++;
        ps_done = 1'b0;
        glitch_on = 1'b0;
        if (rst) begin
            dly = 0;
            glitch_cnt = 0;
            busy_prev = 1'b0;
            for (int c = 0; c < NCH; c++) mtap[c] = 0;
        end else begin
            if (busy && !busy_prev) begin
                step_no = 0; done_cnt = 0; res_n = 0; hdec0 = 0;
                seen_inc0 = 1'b0; ch1_inc_seen = 1'b0; glitch_fired = 1'b0;
            end
            busy_prev = busy;
            if (glitch_cnt > 0) begin
                glitch_cnt--;
                glitch_on = (glitch_cnt == 1);
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    ps_done = 1'b1;
                    mtap[pend_ch] = pend_dir ? mtap[pend_ch] + 1 : mtap[pend_ch] - 1;
                    if (glitch_arm && !glitch_fired && pend_ch == 0 && pend_dir && mtap[0] == 7) begin
                        glitch_fired = 1'b1;
                        glitch_cnt = 4;
                    end
                end
            end
            if (ps_en) begin
                step_no++;
                en_cnt++;
                if (ch_sel == 1'b0 && !ps_incdec && !seen_inc0) hdec0++;
                if (ch_sel == 1'b0 && ps_incdec) seen_inc0 = 1'b1;
                if (ch_sel == 1'b1 && ps_incdec) ch1_inc_seen = 1'b1;
                if (step_no == withhold_step) begin
                    tmo_en_cyc = cyc;
                end else begin
                    dly = 3;
                    pend_ch = int'(ch_sel);
                    pend_dir = ps_incdec;
                end
            end
            if (res_valid) begin
                if (res_n == 0) res_cyc0 = cyc;
                if (res_n < 4) begin
                    res_l[res_n] = int'(res_left);
                    res_w[res_n] = int'(res_width);
                end
                res_n++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input string tag, input int poke_at);
        int n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (poke_at > 0 && n == poke_at) begin
                check({tag, "_busy_mid"}, {31'b0, busy}, 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'b0, (n < BUDGET)}, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int l0, input int w0,
                             input int l1, input int w1, input logic [1:0] lk,
                             input logic [1:0] fl, input int t0, input int t1);
        check({tag, "_nres"},    res_n, 2);
        check({tag, "_left0"},   res_l[0], l0);
        check({tag, "_width0"},  res_w[0], w0);
        check({tag, "_left1"},   res_l[1], l1);
        check({tag, "_width1"},  res_w[1], w1);
        check({tag, "_locked"},  {30'b0, ch_locked}, {30'b0, lk});
        check({tag, "_fail"},    {30'b0, ch_fail}, {30'b0, fl});
        check({tag, "_tap0"},    mtap[0], t0);
        check({tag, "_tap1"},    mtap[1], t1);
        check({tag, "_ndone"},   done_cnt, 1);
        check({tag, "_busy"},    {31'b0, busy}, 0);
        check({tag, "_chsel"},   {31'b0, ch_sel}, 0);
    endtask

    initial begin
        int n;
        int snap;
        int lat;
        rst = 1'b1;
        start = 1'b0;
        mask[0] = '0;
        mask[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {13'b0, ch_sel, ps_en, ps_incdec, busy, done, ch_locked, ch_fail,
               res_valid, res_left, res_width}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: ch0 good 5..12, ch1 good 0..3; extra start mid-run must be ignored
        mask[0] = 16'h1FE0;
        mask[1] = 16'h000F;
        run_scan("t1", 30);
        check_run("t1", 5, 8, 0, 4, 2'b11, 2'b00, 9, 2);

        // 2 + 6a: two width-3 windows; ch0 starts parked at 9
        mask[0] = 16'h0E1C;
        mask[1] = 16'h000F;
        run_scan("t2", 0);
        check("t2_home_decs", hdec0, 9);
        check_run("t2", 2, 3, 0, 4, 2'b10, 2'b01, 8, 2);

        // 3: tie between 1..4 and 8..11; ch1 window touches the last tap
        mask[0] = 16'h0F1E;
        mask[1] = 16'hF000;
        run_scan("t3", 0);
        check_run("t3", 1, 4, 12, 4, 2'b11, 2'b00, 3, 14);

        // 4: one-cycle glitch at tap 7 splits 4..10; ch1 has no good tap at all
        mask[0] = 16'h07F0;
        mask[1] = 16'h0000;
        glitch_arm = 1'b1;
        run_scan("t4", 0);
        glitch_arm = 1'b0;
        check("t4_glitch_fired", {31'b0, glitch_fired}, 1);
        check_run("t4", 4, 3, 0, 0, 2'b00, 2'b11, 8, 8);

        // 5: fifth step never completes (a ch0 homing step from tap 4)
        mask[0] = 16'h1FE0;
        mask[1] = 16'h3FC0;
        withhold_step = 5;
        run_scan("t5", 0);
        withhold_step = 0;
        lat = res_cyc0 - tmo_en_cyc;
        check("t5_tmo_latency", {31'b0, (lat >= PS_TMO && lat <= PS_TMO + 4)}, 1);
        check_run("t5", 0, 0, 6, 8, 2'b10, 2'b01, 4, 10);

        // 6b: reset while ch1 waits for an increment step
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        n = 0;
        while (!ch1_inc_seen && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_nwait", {31'b0, (n < BUDGET)}, 1);
        check("t6_busy_before", {31'b0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_outputs",
              {13'b0, ch_sel, ps_en, ps_incdec, busy, done, ch_locked, ch_fail,
               res_valid, res_left, res_width}, 0);
        rst = 1'b0;
        snap = en_cnt;
        repeat (40) @(negedge clk);
        check("t6_no_steps", en_cnt - snap, 0);
        check("t6_idle_busy", {31'b0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
